// File: rtl/stack_cpu_controller_pkg.sv
// Shared types for the stack-machine control unit: opcodes, ALU codes, state encodings, control vector.
package stack_cpu_controller_pkg;

    localparam int unsigned OPC_W   = 3;
    localparam int unsigned ALUOP_W = 2;
    localparam int unsigned STATE_W = 4;

    typedef enum logic [OPC_W-1:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_NOT  = 3'd3,
        OP_PUSH = 3'd4,
        OP_POP  = 3'd5,
        OP_JMP  = 3'd6,
        OP_JZ   = 3'd7
    } opc_t;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_NOT = 2'd3
    } aluop_t;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_POP_A  = 4'd3,
        S_POP_B  = 4'd4,
        S_EXEC   = 4'd5,
        S_MEM_RD = 4'd6,
        S_MEM_WR = 4'd7,
        S_PUSH_M = 4'd8,
        S_JZ     = 4'd9
    } state_t;

    typedef struct packed {
        logic [ALUOP_W-1:0] alu_op;
        logic               pc_write;
        logic               pc_write_cond;
        logic               pc_src;
        logic               i_or_d;
        logic               mem_read;
        logic               mem_write;
        logic               ir_write;
        logic               m_to_s;
        logic               ld_a;
        logic               ld_b;
        logic               src_a;
        logic               src_b;
        logic               push;
        logic               pop;
        logic               tos;
        logic               instr_done;
    } ctrl_t;

endpackage

// File: rtl/stack_cpu_controller_if.sv
// Controller <-> datapath bundle: opcode/mem handshake in, every datapath control line out.
interface stack_cpu_controller_if;
    import stack_cpu_controller_pkg::*;

    logic [OPC_W-1:0]   opcode;
    logic               mem_ready;
    logic [ALUOP_W-1:0] ALUop;
    logic               PCWrite;
    logic               PCWriteCond;
    logic               PCsrc;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               IRWrite;
    logic               MtoS;
    logic               ldA;
    logic               ldB;
    logic               srcA;
    logic               srcB;
    logic               push;
    logic               pop;
    logic               tos;
    logic               instr_done;
    logic [STATE_W-1:0] state_dbg;

    modport master (
        input  opcode, mem_ready,
        output ALUop, PCWrite, PCWriteCond, PCsrc, IorD, MemRead, MemWrite, IRWrite, MtoS,
               ldA, ldB, srcA, srcB, push, pop, tos, instr_done, state_dbg
    );

    modport slave (
        output opcode, mem_ready,
        input  ALUop, PCWrite, PCWriteCond, PCsrc, IorD, MemRead, MemWrite, IRWrite, MtoS,
               ldA, ldB, srcA, srcB, push, pop, tos, instr_done, state_dbg
    );

endinterface

// File: rtl/stack_cpu_controller_decode.sv
// Combinational control decode: (state, opcode, mem_ready) -> datapath control vector.
module stack_cpu_controller_decode
    import stack_cpu_controller_pkg::*;
(
    input  state_t state,
    input  opc_t   op,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read = 1'b1;
                // PC <= PC + 1 and IR load only once the instruction word is present
                if (mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.src_a    = 1'b1;
                    ctrl.src_b    = 1'b1;
                    ctrl.alu_op   = ALU_ADD;
                    ctrl.pc_write = 1'b1;
                end
            end
            S_DECODE: begin
                ctrl.tos  = 1'b1;
                ctrl.ld_a = 1'b1;
                if (op == OP_JMP) begin
                    ctrl.pc_src     = 1'b1;
                    ctrl.pc_write   = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
            end
            S_POP_A: begin
                ctrl.pop  = 1'b1;
                ctrl.ld_a = 1'b1;
            end
            S_POP_B: begin
                ctrl.pop  = 1'b1;
                ctrl.ld_b = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_op     = op[ALUOP_W-1:0];
                ctrl.push       = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_RD: begin
                ctrl.i_or_d   = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_PUSH_M: begin
                ctrl.m_to_s     = 1'b1;
                ctrl.push       = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.i_or_d     = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_JZ: begin
                ctrl.pc_src        = 1'b1;
                ctrl.pc_write_cond = 1'b1;
                ctrl.instr_done    = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/stack_cpu_controller.sv
// Multicycle control FSM for the 8-bit stack machine; one state per cycle, memory waits via mem_ready.
module stack_cpu_controller
    import stack_cpu_controller_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    stack_cpu_controller_if.master bus
);

    state_t state;
    state_t state_nxt;
    opc_t   op_q;
    opc_t   op_eff;
    ctrl_t  ctrl;

    // Opcode is captured in DECODE so later states do not depend on IR stability
    assign op_eff = (state == S_DECODE) ? opc_t'(bus.opcode) : op_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            op_q  <= OP_ADD;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE) begin
                op_q <= opc_t'(bus.opcode);
            end
        end
    end

    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE:   state_nxt = S_FETCH;
            S_FETCH:  state_nxt = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op_eff)
                    OP_PUSH: state_nxt = S_MEM_RD;
                    OP_JMP:  state_nxt = S_FETCH;
                    OP_JZ:   state_nxt = S_JZ;
                    default: state_nxt = S_POP_A;
                endcase
            end
            S_POP_A: begin
                case (op_eff)
                    OP_NOT:  state_nxt = S_EXEC;
                    OP_POP:  state_nxt = S_MEM_WR;
                    default: state_nxt = S_POP_B;
                endcase
            end
            S_POP_B:  state_nxt = S_EXEC;
            S_EXEC:   state_nxt = S_FETCH;
            S_MEM_RD: state_nxt = bus.mem_ready ? S_PUSH_M : S_MEM_RD;
            S_PUSH_M: state_nxt = S_FETCH;
            S_MEM_WR: state_nxt = bus.mem_ready ? S_FETCH : S_MEM_WR;
            S_JZ:     state_nxt = S_FETCH;
            default:  state_nxt = S_IDLE;
        endcase
    end

    stack_cpu_controller_decode u_decode (
        .state     (state),
        .op        (op_eff),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl)
    );

    assign bus.ALUop       = ctrl.alu_op;
    assign bus.PCWrite     = ctrl.pc_write;
    assign bus.PCWriteCond = ctrl.pc_write_cond;
    assign bus.PCsrc       = ctrl.pc_src;
    assign bus.IorD        = ctrl.i_or_d;
    assign bus.MemRead     = ctrl.mem_read;
    assign bus.MemWrite    = ctrl.mem_write;
    assign bus.IRWrite     = ctrl.ir_write;
    assign bus.MtoS        = ctrl.m_to_s;
    assign bus.ldA         = ctrl.ld_a;
    assign bus.ldB         = ctrl.ld_b;
    assign bus.srcA        = ctrl.src_a;
    assign bus.srcB        = ctrl.src_b;
    assign bus.push        = ctrl.push;
    assign bus.pop         = ctrl.pop;
    assign bus.tos         = ctrl.tos;
    assign bus.instr_done  = ctrl.instr_done;
    assign bus.state_dbg   = STATE_W'(state);

endmodule

// File: tb/tb_stack_cpu_controller.sv
// Scoreboard bench for stack_cpu_controller: directed per-cycle expectations plus a random invariant run.
module tb_stack_cpu_controller;
    import stack_cpu_controller_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stack_cpu_controller_if bus();

    stack_cpu_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Control-vector bit positions, MSB first: ALUop[17:16], PCWrite .. instr_done[0]
    localparam logic [17:0] B_DONE  = 18'h00001;
    localparam logic [17:0] B_TOS   = 18'h00002;
    localparam logic [17:0] B_POP   = 18'h00004;
    localparam logic [17:0] B_PUSH  = 18'h00008;
    localparam logic [17:0] B_SRCB  = 18'h00010;
    localparam logic [17:0] B_SRCA  = 18'h00020;
    localparam logic [17:0] B_LDB   = 18'h00040;
    localparam logic [17:0] B_LDA   = 18'h00080;
    localparam logic [17:0] B_MTOS  = 18'h00100;
    localparam logic [17:0] B_IRW   = 18'h00200;
    localparam logic [17:0] B_MW    = 18'h00400;
    localparam logic [17:0] B_MR    = 18'h00800;
    localparam logic [17:0] B_IORD  = 18'h01000;
    localparam logic [17:0] B_PCSRC = 18'h02000;
    localparam logic [17:0] B_PCWC  = 18'h04000;
    localparam logic [17:0] B_PCW   = 18'h08000;
    localparam logic [17:0] A_SUB   = 18'h10000;
    localparam logic [17:0] A_AND   = 18'h20000;
    localparam logic [17:0] A_NOT   = 18'h30000;

    localparam logic [17:0] V_FWAIT = B_MR;
    localparam logic [17:0] V_FRDY  = B_MR | B_IRW | B_SRCA | B_SRCB | B_PCW;
    localparam logic [17:0] V_DEC   = B_TOS | B_LDA;
    localparam logic [17:0] V_DJMP  = B_TOS | B_LDA | B_PCSRC | B_PCW | B_DONE;
    localparam logic [17:0] V_POPA  = B_POP | B_LDA;
    localparam logic [17:0] V_POPB  = B_POP | B_LDB;
    localparam logic [17:0] V_EXEC  = B_PUSH | B_DONE;
    localparam logic [17:0] V_MRD   = B_IORD | B_MR;
    localparam logic [17:0] V_PUSHM = B_MTOS | B_PUSH | B_DONE;
    localparam logic [17:0] V_MWR   = B_IORD | B_MW;
    localparam logic [17:0] V_JZ    = B_PCSRC | B_PCWC | B_DONE;

    logic [17:0] act_vec;
    assign act_vec = {bus.ALUop, bus.PCWrite, bus.PCWriteCond, bus.PCsrc, bus.IorD,
                      bus.MemRead, bus.MemWrite, bus.IRWrite, bus.MtoS, bus.ldA, bus.ldB,
                      bus.srcA, bus.srcB, bus.push, bus.pop, bus.tos, bus.instr_done};

    logic [3:0]  exp_st_q[$];
    logic [17:0] exp_vec_q[$];
    int          exp_tag_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          step_no  = 0;
    logic [3:0]  prev_st  = 4'd0;
    int          done_cnt = 0;

    task automatic push_exp(input state_t st, input logic [17:0] vec);
        exp_st_q.push_back(4'(st));
        exp_vec_q.push_back(vec);
        exp_tag_q.push_back(step_no);
        step_no++;
    endtask

    // Drive one cycle of inputs, queue the expected state/control vector, advance to next edge
    task automatic step(input logic [2:0] op, input logic rdy, input state_t st, input logic [17:0] vec);
        bus.opcode    = op;
        bus.mem_ready = rdy;
        push_exp(st, vec);
        @(posedge clk);
        #1;
    endtask

    // Monitor: scoreboard compare plus structural invariants, sampled mid-cycle
    always @(negedge clk) begin
        logic [3:0]  e_st;
        logic [17:0] e_vec;
        int          e_tag;
        if (exp_st_q.size() > 0) begin
            e_st  = exp_st_q.pop_front();
            e_vec = exp_vec_q.pop_front();
            e_tag = exp_tag_q.pop_front();
            checks++;
            if (bus.state_dbg !== e_st || act_vec !== e_vec) begin
                failures++;
                $display("FAIL ctrl_vec step=%0d state=%0d expected_state=%0d ctrl=%05h expected_ctrl=%05h",
                         e_tag, bus.state_dbg, e_st, act_vec, e_vec);
            end
        end

        a_push_pop: assert (!(bus.push && bus.pop)) else begin
            failures++;
            $display("FAIL push_pop state=%0d push=%b pop=%b required not both", bus.state_dbg, bus.push, bus.pop);
        end
        a_rd_wr: assert (!(bus.MemRead && bus.MemWrite)) else begin
            failures++;
            $display("FAIL rd_wr state=%0d MemRead=%b MemWrite=%b required not both",
                     bus.state_dbg, bus.MemRead, bus.MemWrite);
        end

        if (bus.state_dbg == 4'(S_FETCH) && prev_st != 4'(S_FETCH) && prev_st != 4'(S_IDLE)) begin
            checks++;
            if (done_cnt != 1) begin
                failures++;
                $display("FAIL done_per_fetch from_state=%0d instr_done_count=%0d required=1", prev_st, done_cnt);
            end
            done_cnt = 0;
        end
        if (bus.state_dbg == 4'(S_IDLE) || bus.state_dbg == 4'(S_FETCH)) begin
            if (prev_st == 4'(S_IDLE)) done_cnt = 0;
        end
        if (bus.instr_done) done_cnt++;
        prev_st = bus.state_dbg;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog time_limit_reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b0;
        bus.opcode    = 3'd0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset, release, IDLE for one cycle, then FETCH waiting on memory
        step(3'd0, 1'b1, S_IDLE, 18'h0);
        rst = 1'b1;
        step(3'd0, 1'b0, S_IDLE, 18'h0);
        step(3'd0, 1'b0, S_FETCH, V_FWAIT);
        step(3'd0, 1'b0, S_FETCH, V_FWAIT);
        step(3'd0, 1'b1, S_FETCH, V_FRDY);

        // ADD; mem_ready low in DECODE must not matter
        step(3'd0, 1'b0, S_DECODE, V_DEC);
        step(3'd0, 1'b1, S_POP_A, V_POPA);
        step(3'd0, 1'b1, S_POP_B, V_POPB);
        step(3'd0, 1'b1, S_EXEC, V_EXEC);

        // ADD with mem_ready tied high: 5 cycles
        step(3'd0, 1'b1, S_FETCH, V_FRDY);
        step(3'd0, 1'b1, S_DECODE, V_DEC);
        step(3'd0, 1'b1, S_POP_A, V_POPA);
        step(3'd0, 1'b1, S_POP_B, V_POPB);
        step(3'd0, 1'b1, S_EXEC, V_EXEC);

        // SUB; opcode input changes after DECODE and must be ignored
        step(3'd1, 1'b1, S_FETCH, V_FRDY);
        step(3'd1, 1'b1, S_DECODE, V_DEC);
        step(3'd3, 1'b1, S_POP_A, V_POPA);
        step(3'd3, 1'b1, S_POP_B, V_POPB);
        step(3'd3, 1'b1, S_EXEC, V_EXEC | A_SUB);

        // AND
        step(3'd2, 1'b1, S_FETCH, V_FRDY);
        step(3'd2, 1'b1, S_DECODE, V_DEC);
        step(3'd2, 1'b1, S_POP_A, V_POPA);
        step(3'd2, 1'b1, S_POP_B, V_POPB);
        step(3'd2, 1'b1, S_EXEC, V_EXEC | A_AND);

        // NOT: single pop, 4 cycles
        step(3'd3, 1'b1, S_FETCH, V_FRDY);
        step(3'd3, 1'b1, S_DECODE, V_DEC);
        step(3'd3, 1'b1, S_POP_A, V_POPA);
        step(3'd3, 1'b1, S_EXEC, V_EXEC | A_NOT);

        // PUSH with 3 wait states in MEM_RD
        step(3'd4, 1'b1, S_FETCH, V_FRDY);
        step(3'd4, 1'b1, S_DECODE, V_DEC);
        step(3'd4, 1'b0, S_MEM_RD, V_MRD);
        step(3'd4, 1'b0, S_MEM_RD, V_MRD);
        step(3'd4, 1'b0, S_MEM_RD, V_MRD);
        step(3'd4, 1'b1, S_MEM_RD, V_MRD);
        step(3'd4, 1'b0, S_PUSH_M, V_PUSHM);

        // POP with one wait state in MEM_WR
        step(3'd5, 1'b1, S_FETCH, V_FRDY);
        step(3'd5, 1'b1, S_DECODE, V_DEC);
        step(3'd5, 1'b1, S_POP_A, V_POPA);
        step(3'd5, 1'b0, S_MEM_WR, V_MWR);
        step(3'd5, 1'b1, S_MEM_WR, V_MWR | B_DONE);

        // JZ then JMP
        step(3'd7, 1'b1, S_FETCH, V_FRDY);
        step(3'd7, 1'b1, S_DECODE, V_DEC);
        step(3'd7, 1'b0, S_JZ, V_JZ);
        step(3'd6, 1'b1, S_FETCH, V_FRDY);
        step(3'd6, 1'b0, S_DECODE, V_DJMP);
        step(3'd0, 1'b0, S_FETCH, V_FWAIT);

        // Reset mid-EXEC: outputs drop immediately, no edge needed
        step(3'd0, 1'b1, S_FETCH, V_FRDY);
        step(3'd0, 1'b1, S_DECODE, V_DEC);
        step(3'd0, 1'b1, S_POP_A, V_POPA);
        step(3'd0, 1'b1, S_POP_B, V_POPB);
        push_exp(S_EXEC, V_EXEC);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.state_dbg !== 4'd0 || act_vec !== 18'h0) begin
            failures++;
            $display("FAIL reset_mid_exec state=%0d ctrl=%05h required state=0 ctrl=00000", bus.state_dbg, act_vec);
        end
        @(posedge clk);
        #1;
        step(3'd0, 1'b1, S_IDLE, 18'h0);
        rst = 1'b1;
        step(3'd0, 1'b0, S_IDLE, 18'h0);
        step(3'd0, 1'b0, S_FETCH, V_FWAIT);

        // Random opcodes and memory handshake; invariants only
        for (int i = 0; i < 10000; i++) begin
            bus.opcode    = 3'($urandom_range(0, 7));
            bus.mem_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end

        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (exp_st_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain pending=%0d required=0", exp_st_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
